// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for the instruction decode queue.
interface decode_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
);
  // fetch side
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  // execute side
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  // head operand fields
  logic [5:0]       op_code;
  logic [5:0]       funct_code;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [15:0]      imm_16;
  logic [25:0]      imm_26;
  // head control flags
  logic             reg_dst;
  logic             reg_wr;
  logic             mem_wr;
  logic             mem_to_reg;
  logic             alu_src;
  logic             jump_en;
  logic             jal_en;
  logic             jr_en;
  logic             beq_en;
  logic             bne_en;
  logic             lui_en;
  logic             d_atomic;
  logic             halt;
  // status
  logic [CNT_W-1:0] count;
  logic             halt_locked;

  // producer/consumer view
  modport master (
    output in_valid, in_instr, out_ready, flush,
    input  in_ready, out_valid, op_code, funct_code, rs, rt, rd, shamt,
           imm_16, imm_26, reg_dst, reg_wr, mem_wr, mem_to_reg, alu_src,
           jump_en, jal_en, jr_en, beq_en, bne_en, lui_en, d_atomic, halt,
           count, halt_locked
  );

  // queue view
  modport slave (
    input  in_valid, in_instr, out_ready, flush,
    output in_ready, out_valid, op_code, funct_code, rs, rt, rd, shamt,
           imm_16, imm_26, reg_dst, reg_wr, mem_wr, mem_to_reg, alu_src,
           jump_en, jal_en, jr_en, beq_en, bne_en, lui_en, d_atomic, halt,
           count, halt_locked
  );
endinterface

// File: rtl/decode_queue.sv
// Instruction decode queue: decodes MIPS words on enqueue and presents the
// oldest decoded entry to the execute pipeline. Supports flush, sticky halt
// lock and LL/SC tagging.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  decode_queue_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC    = 6'h38;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic reg_dst;
    logic reg_wr;
    logic mem_wr;
    logic mem_to_reg;
    logic alu_src;
    logic jump_en;
    logic jal_en;
    logic jr_en;
    logic beq_en;
    logic bne_en;
    logic lui_en;
    logic d_atomic;
    logic halt;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             halt_locked;

  ctrl_t            dec;
  entry_t           head_e;
  logic             push;
  logic             pop;
  logic             out_valid_c;
  logic             in_ready_c;

  // handshake qualification; a pop frees a slot for a same-cycle push
  always_comb begin
    out_valid_c = (count != '0);
    pop         = out_valid_c && bus.out_ready;
    in_ready_c  = ((count < CNT_W'(DEPTH)) || pop) && !halt_locked && !bus.flush;
    push        = bus.in_valid && in_ready_c;
  end

  // decode the incoming word into control flags
  always_comb begin
    dec = '0;
    case (bus.in_instr[31:26])
      OP_RTYPE: begin
        dec.reg_dst = 1'b1;
        if (bus.in_instr[5:0] == FN_JR) begin
          dec.jr_en = 1'b1;
        end else begin
          dec.reg_wr = 1'b1;
        end
      end
      OP_J: begin
        dec.jump_en = 1'b1;
      end
      OP_JAL: begin
        dec.jump_en = 1'b1;
        dec.jal_en  = 1'b1;
        dec.reg_wr  = 1'b1;
      end
      OP_BEQ: begin
        dec.beq_en = 1'b1;
      end
      OP_BNE: begin
        dec.bne_en = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alu_src = 1'b1;
        dec.reg_wr  = 1'b1;
      end
      OP_LUI: begin
        dec.lui_en = 1'b1;
        dec.reg_wr = 1'b1;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wr     = 1'b1;
      end
      OP_SW: begin
        dec.alu_src = 1'b1;
        dec.mem_wr  = 1'b1;
      end
      OP_LL: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wr     = 1'b1;
        dec.d_atomic   = 1'b1;
      end
      OP_SC: begin
        dec.alu_src  = 1'b1;
        dec.mem_wr   = 1'b1;
        dec.reg_wr   = 1'b1;
        dec.d_atomic = 1'b1;
      end
      OP_HALT: begin
        dec.halt = 1'b1;
      end
      default: begin
        dec = '0;
      end
    endcase
  end

  // entry storage; contents are never observed while the slot is empty
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[tail] <= '{ctrl: dec, instr: bus.in_instr};
    end
  end

  // pointers, occupancy and halt lock
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      halt_locked <= 1'b0;
    end else if (bus.flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      halt_locked <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && dec.halt) begin
        halt_locked <= 1'b1;
      end
    end
  end

  // head presentation, forced to zero while the queue is empty
  always_comb begin
    head_e = '0;
    if (out_valid_c) begin
      head_e = mem[head];
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.count       = count;
  assign bus.halt_locked = halt_locked;

  assign bus.op_code     = head_e.instr[31:26];
  assign bus.rs          = head_e.instr[25:21];
  assign bus.rt          = head_e.instr[20:16];
  assign bus.rd          = head_e.instr[15:11];
  assign bus.shamt       = head_e.instr[10:6];
  assign bus.funct_code  = head_e.instr[5:0];
  assign bus.imm_16      = head_e.instr[15:0];
  assign bus.imm_26      = head_e.instr[25:0];

  assign bus.reg_dst     = head_e.ctrl.reg_dst;
  assign bus.reg_wr      = head_e.ctrl.reg_wr;
  assign bus.mem_wr      = head_e.ctrl.mem_wr;
  assign bus.mem_to_reg  = head_e.ctrl.mem_to_reg;
  assign bus.alu_src     = head_e.ctrl.alu_src;
  assign bus.jump_en     = head_e.ctrl.jump_en;
  assign bus.jal_en      = head_e.ctrl.jal_en;
  assign bus.jr_en       = head_e.ctrl.jr_en;
  assign bus.beq_en      = head_e.ctrl.beq_en;
  assign bus.bne_en      = head_e.ctrl.bne_en;
  assign bus.lui_en      = head_e.ctrl.lui_en;
  assign bus.d_atomic    = head_e.ctrl.d_atomic;
  assign bus.halt        = head_e.ctrl.halt;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (DEPTH=4).
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;

  logic CLK;
  logic nRST;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();

  decode_queue #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] sb [$];
  int          m_cnt;
  bit          m_lock;
  int          n_pass;
  int          n_total;

  // count one comparison and report it if it disagrees
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // expected flags {reg_dst,reg_wr,mem_wr,mem_to_reg,alu_src,jump_en,jal_en,jr_en,beq_en,bne_en,lui_en,d_atomic,halt}
  function automatic logic [12:0] exp_flags(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic rdst, rw, mw, m2r, asrc, j, jal, jr, beq, bne, lui, at, h;
    op = w[31:26];
    fn = w[5:0];
    {rdst, rw, mw, m2r, asrc, j, jal, jr, beq, bne, lui, at, h} = '0;
    if (op == 6'h00) begin rdst = 1; jr = (fn == 6'h08); rw = (fn != 6'h08); end
    if (op == 6'h02 || op == 6'h03) j = 1;
    if (op == 6'h03) begin jal = 1; rw = 1; end
    if (op == 6'h04) beq = 1;
    if (op == 6'h05) bne = 1;
    if (op >= 6'h09 && op <= 6'h0E) begin asrc = 1; rw = 1; end
    if (op == 6'h0F) begin lui = 1; rw = 1; end
    if (op == 6'h23 || op == 6'h30) begin asrc = 1; m2r = 1; rw = 1; end
    if (op == 6'h30 || op == 6'h38) at = 1;
    if (op == 6'h2B || op == 6'h38) begin asrc = 1; mw = 1; end
    if (op == 6'h38) rw = 1;
    if (op == 6'h3F) h = 1;
    return {rdst, rw, mw, m2r, asrc, j, jal, jr, beq, bne, lui, at, h};
  endfunction

  function automatic logic [12:0] dut_flags();
    return {bus.reg_dst, bus.reg_wr, bus.mem_wr, bus.mem_to_reg, bus.alu_src,
            bus.jump_en, bus.jal_en, bus.jr_en, bus.beq_en, bus.bne_en,
            bus.lui_en, bus.d_atomic, bus.halt};
  endfunction

  // sample at negedge, compare against model, advance model, return at posedge+1
  task automatic cycle();
    bit exp_ready, m_pop, m_push;
    logic [31:0] w;
    @(negedge CLK);
    m_pop     = (m_cnt != 0) && bus.out_ready;
    exp_ready = ((m_cnt < DEPTH) || m_pop) && !m_lock && !bus.flush;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(m_cnt != 0));
    check("count", 32'(bus.count), 32'(m_cnt));
    check("halt_locked", 32'(bus.halt_locked), 32'(m_lock));
    if (m_cnt != 0) begin
      w = sb[0];
      check("head_fields", {bus.op_code, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct_code}, w);
      check("head_imm", {bus.imm_26[25:16], bus.imm_16}, w[25:0]);
      check("head_flags", 32'(dut_flags()), 32'(exp_flags(w)));
    end else begin
      check("empty_zero", 32'(dut_flags()) | {bus.op_code, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct_code}
                          | 32'(bus.imm_16) | 32'(bus.imm_26), 32'h0);
    end
    m_push = bus.in_valid && exp_ready;
    if (m_pop) void'(sb.pop_front());
    if (bus.flush) begin
      sb.delete();
      m_cnt  = 0;
      m_lock = 0;
    end else begin
      if (m_push) begin
        sb.push_back(bus.in_instr);
        if (bus.in_instr[31:26] == 6'h3F) m_lock = 1;
      end
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [31:0] instr, input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    bus.flush     = fl;
    cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [16];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0E,
            6'h0F, 6'h23, 6'h2B, 6'h30, 6'h38, 6'h3F, 6'h11, 6'h00};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 15)];
    if (w[31:26] == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
    return w;
  endfunction

  initial begin
    n_pass = 0; n_total = 0; m_cnt = 0; m_lock = 0;
    bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 0; bus.flush = 0;
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_halt_locked", 32'(bus.halt_locked), 32'h0);
    nRST = 1;
    drive(0, '0, 0, 0);

    // LW at head one cycle after enqueue
    drive(1, 32'h8C220004, 0, 0);
    check("lw_rs", 32'(bus.rs), 32'd1);
    check("lw_rt", 32'(bus.rt), 32'd2);
    check("lw_imm16", 32'(bus.imm_16), 32'h4);
    check("lw_ctrl", 32'({bus.alu_src, bus.mem_to_reg, bus.reg_wr}), 32'h7);
    check("lw_count", 32'(bus.count), 32'd1);

    // fill to DEPTH, then push+pop while full across the pointer wrap
    drive(1, 32'h2402_0011, 0, 0);
    drive(1, 32'hAC43_0008, 0, 0);
    drive(1, 32'h1043_FFFC, 0, 0);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 6; i++) drive(1, 32'h3C01_0000 | 32'(i), 1, 0);
    check("full_pp_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 5; i++) drive(0, '0, 1, 0);

    // JR and JAL decode
    drive(1, 32'h03E00008, 0, 0);
    check("jr_en", 32'(bus.jr_en), 32'h1);
    check("jr_reg_wr", 32'(bus.reg_wr), 32'h0);
    check("jr_rs", 32'(bus.rs), 32'd31);
    drive(1, 32'h0C000010, 0, 0);
    drive(0, '0, 1, 0);
    check("jal_ctrl", 32'({bus.jal_en, bus.jump_en, bus.reg_wr}), 32'h7);
    check("jal_imm26", 32'(bus.imm_26), 32'h10);
    drive(0, '0, 1, 0);

    // sticky halt lock, drain, release by flush
    drive(1, 32'hFFFFFFFF, 0, 0);
    check("halt_head", 32'(bus.halt), 32'h1);
    for (int i = 0; i < 3; i++) drive(1, 32'h0, 0, 0);
    check("halt_locked", 32'(bus.halt_locked), 32'h1);
    check("halt_count", 32'(bus.count), 32'd1);
    drive(1, 32'h0, 1, 0);
    drive(0, '0, 0, 1);
    check("flush_unlock", 32'(bus.halt_locked), 32'h0);

    // flush coinciding with pop and push
    drive(1, 32'h2001_0001, 0, 0);
    drive(1, 32'h2001_0002, 0, 0);
    drive(1, 32'h2001_0003, 0, 0);
    drive(1, 32'h1234_5678, 1, 1);
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    drive(0, '0, 0, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 40) == 0));
    drive(0, '0, 0, 1);

    // asynchronous reset mid-push with two entries and the lock set
    drive(1, 32'h2001_00AA, 0, 0);
    drive(1, 32'hFC00_0000, 0, 0);
    bus.in_valid = 1; bus.in_instr = 32'h2001_00BB;
    check("pre_rst_count", 32'(bus.count), 32'd2);
    nRST = 0;
    #1;
    check("arst_count", 32'(bus.count), 32'h0);
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_halt_locked", 32'(bus.halt_locked), 32'h0);
    sb.delete(); m_cnt = 0; m_lock = 0;
    @(posedge CLK);
    #1;
    bus.in_valid = 0;
    nRST = 1;
    drive(1, 32'h8C220004, 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction decode buffer between fetch and the execute pipeline of each core.
- Accepts raw 32-bit MIPS instructions over a valid/ready handshake and decodes them on enqueue.
- Holds up to DEPTH decoded entries and presents the oldest entry with control flags and operand fields.
- Supports pipeline flush, sticky halt and LL/SC tagging.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  fetch offers instruction
- in_instr  in  32  raw instruction word
- in_ready  out  1  queue accepts this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- flush  in  1  discard all entries and clear halt lock
- op_code  out  6  head instr[31:26]
- funct_code  out  6  head instr[5:0]
- rs, rt, rd  out  5 each  head instr[25:21], [20:16], [15:11]
- shamt  out  5  head instr[10:6]
- imm_16  out  16  head instr[15:0]
- imm_26  out  26  head instr[25:0]
- reg_dst, reg_wr, mem_wr, mem_to_reg, alu_src  out  1 each  decoded head flags
- jump_en, jal_en, jr_en, beq_en, bne_en, lui_en, d_atomic, halt  out  1 each  decoded head flags
- count  out  CNT_W  current occupancy
- halt_locked  out  1  HALT accepted; further input refused

Behaviour:
- Reset (nRST=0, async): head/tail pointers=0, count=0, halt_locked=0, out_valid=0. Decoded outputs read as all-zero while out_valid=0.
- Enqueue when in_valid && in_ready. in_ready = (count<DEPTH || dequeue this cycle) && !halt_locked && !flush.
- Dequeue when out_valid && out_ready. out_valid = (count!=0).
- Simultaneous push and pop: legal when full (count unchanged) and when count=1. Pointers wrap modulo DEPTH.
- Head is registered storage. An entry enqueued in cycle N is visible at the head no earlier than cycle N+1; there is no same-cycle bypass.
- Decode happens at enqueue; stored flags are stable while an entry waits. Opcodes (hex):
  - 00 R-type: reg_dst=1, reg_wr=1. If funct=08 (JR): jr_en=1, reg_wr=0.
  - 02 J: jump_en=1.
  - 03 JAL: jump_en=1, jal_en=1, reg_wr=1.
  - 04 BEQ: beq_en=1. 05 BNE: bne_en=1.
  - 09/0A/0B/0C/0D/0E (ADDIU/SLTI/SLTIU/ANDI/ORI/XORI): alu_src=1, reg_wr=1.
  - 0F LUI: lui_en=1, reg_wr=1.
  - 23 LW: alu_src=1, mem_to_reg=1, reg_wr=1.
  - 2B SW: alu_src=1, mem_wr=1.
  - 30 LL: as LW plus d_atomic=1.
  - 38 SC: alu_src=1, mem_wr=1, reg_wr=1, d_atomic=1.
  - 3F HALT: halt=1.
  - Any other opcode: all flags 0.
- Halt lock: enqueuing a HALT sets halt_locked=1 from the next cycle. in_ready stays 0 until flush. Entries already queued still drain normally.
- Flush (synchronous): next cycle count=0, pointers=0, halt_locked=0. A dequeue coinciding with flush is still counted by the consumer. A push coinciding with flush is dropped, since in_ready=0.
- Reset asserted mid-operation clears everything immediately, regardless of handshakes in flight.

Test Plan:
- Reset then push 0x8C220004 (LW): next cycle out_valid=1, rs=1, rt=2, imm_16=0x0004, alu_src=mem_to_reg=reg_wr=1, count=1.
- DEPTH=4: push 4 instrs with out_ready=0 -> count=4, in_ready=0. Then push+pop in the same cycle -> count stays 4, FIFO order preserved across pointer wrap.
- Push 0x03E00008 (JR $31) -> jr_en=1, reg_wr=0, rs=31. Push 0x0C000010 (JAL) -> jal_en=jump_en=reg_wr=1, imm_26=0x10.
- Push 0xFFFFFFFF (HALT) then 0x00000000 -> halt_locked=1, in_ready=0, second instr not accepted. Draining yields halt=1. Then flush -> halt_locked=0, count=0.
- 3 entries queued, assert flush together with out_ready=1 and in_valid=1 -> next cycle count=0, out_valid=0, pushed word absent.
- Drop nRST while count=2 mid-push -> count=0, out_valid=0, halt_locked=0 asynchronously, before the next CLK edge.
